// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer for boot, load-use stall, branch redirect and halt drain.
// Optional saturating perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
  parameter int         FLUSH_CYCLES = 3,
  parameter int         DRAIN_CYCLES = 4,
  parameter logic [5:0] HALT_OPCODE  = 6'h3F,
  parameter int         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      ir_if,
  input  logic             ld_use_haz,
  input  logic             br_taken,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [2:0]       state_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
    $error("fetch_ctrl: FLUSH_CYCLES must be 1..7");
  end
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
    $error("fetch_ctrl: DRAIN_CYCLES must be 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cntw
    $error("fetch_ctrl: CNT_W must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_FLUSH  = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [3:0] FLUSH_LD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES - 1);

  state_t     r_state;
  state_t     w_nstate;
  logic [3:0] r_cnt;
  logic [3:0] w_ncnt;
  logic [3:0] w_cnt_dec;
  logic       w_is_halt;
  logic       w_redir;
  logic       w_stall;
  logic       w_unused_ir;

  assign w_is_halt   = (ir_if[31:26] == HALT_OPCODE);
  assign w_unused_ir = ^ir_if[25:0];
  assign w_cnt_dec   = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
  assign state_o     = r_state;

  // State and down-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  // Next-state and Mealy outputs; a taken branch redirects the same cycle.
  always_comb begin
    w_nstate    = r_state;
    w_ncnt      = r_cnt;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    w_redir     = 1'b0;
    w_stall     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_nstate = S_RUN;
      end
      S_RUN: begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        if (br_taken) begin
          w_redir = 1'b1;
        end else if (ld_use_haz) begin
          w_stall     = 1'b1;
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (w_is_halt) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          w_nstate    = S_DRAIN;
          w_ncnt      = DRAIN_LD;
        end
      end
      S_FLUSH: begin
        pc_en       = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        w_ncnt      = w_cnt_dec;
        if (r_cnt == 4'd0) w_nstate = S_RUN;
      end
      S_DRAIN: begin
        if (br_taken) begin
          w_redir = 1'b1;
        end else begin
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          w_ncnt      = w_cnt_dec;
          if (r_cnt == 4'd0) w_nstate = S_HALTED;
        end
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        w_nstate = S_IDLE;
        w_ncnt   = 4'd0;
      end
    endcase
    if (w_redir) begin
      pc_en       = 1'b1;
      pc_sel      = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_nstate = S_FLUSH;
        w_ncnt   = FLUSH_LD;
      end else begin
        w_nstate = S_RUN;
        w_ncnt   = 4'd0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] r_instr;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;
  logic             w_ev_instr;

  assign w_ev_instr = (r_state == S_RUN) && pc_en && !pc_sel;
  assign instr_cnt  = r_instr;
  assign stall_cnt  = r_stall;
  assign flush_cnt  = r_flush;

  // Saturating fetch, stall and redirect event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (w_ev_instr && r_instr != '1) r_instr <= r_instr + CNT_W'(1);
      if (w_stall && r_stall != '1)    r_stall <= r_stall + CNT_W'(1);
      if (w_redir && r_flush != '1)    r_flush <= r_flush + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus random traffic against a
// mode/remaining-cycles reference model of the fetch sequencer.
module tb_fetch_ctrl;
  localparam int FC = 3;
  localparam int DC = 4;
  localparam logic [31:0] HALT_IR = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir_if = '0;
  logic        ld_use_haz = 1'b0;
  logic        br_taken = 1'b0;
  logic        pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush, halted;
  logic [2:0]  state_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_cnt, stall_cnt, flush_cnt;
`endif

  fetch_ctrl #(
    .FLUSH_CYCLES(FC),
    .DRAIN_CYCLES(DC),
    .HALT_OPCODE(6'h3F),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .ir_if(ir_if),
    .ld_use_haz(ld_use_haz),
    .br_taken(br_taken),
    .pc_en(pc_en),
    .pc_sel(pc_sel),
    .if_id_en(if_id_en),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .halted(halted),
    .state_o(state_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .instr_cnt(instr_cnt),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: running flag, remaining flush/drain cycles, halted flag.
  bit m_run;
  bit m_halt;
  int m_fl;
  int m_dr;
  int m_instr;
  int m_stall;
  int m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, pc_en, pc_sel, if_id_en, if_id_flush,
            id_ex_flush, halted, state_o};
  endfunction

  task automatic m_clear();
    m_run = 0; m_halt = 0; m_fl = 0; m_dr = 0;
    m_instr = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    start = 0; ir_if = '0; ld_use_haz = 0; br_taken = 0;
    rst_n = 0;
    #1;
    chk({tag, "_rst"}, outs(), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_rst_flush_cnt"}, flush_cnt, 32'd0);
`endif
    m_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic cyc(input string tag, input bit s, input logic [31:0] ir,
                     input bit ld, input bit br);
    bit hop;
    bit e_pc, e_sel, e_ifen, e_iff, e_idf, e_h, mask_ifen;
    logic [2:0] e_st;
    logic [31:0] o, e;
    @(negedge clk);
    start = s; ir_if = ir; ld_use_haz = ld; br_taken = br;
    #1;
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_instr_cnt"}, instr_cnt, m_instr);
    chk({tag, "_stall_cnt"}, stall_cnt, m_stall);
    chk({tag, "_flush_cnt"}, flush_cnt, m_flush);
`endif
    hop = (ir[31:26] == 6'h3F);
    {e_pc, e_sel, e_ifen, e_iff, e_idf, e_h, mask_ifen} = '0;
    if (m_halt) begin
      e_st = 3'd4; e_h = 1;
    end else if (m_dr > 0) begin
      e_st = 3'd3;
      if (br) begin
        {e_pc, e_sel, e_ifen, e_iff, e_idf} = 5'b11111;
        m_dr = 0; m_fl = FC - 1; m_flush++;
      end else begin
        e_ifen = 1; e_iff = 1;
        m_dr--;
        if (m_dr == 0) m_halt = 1;
      end
    end else if (m_fl > 0) begin
      e_st = 3'd2; e_pc = 1; e_iff = 1; e_idf = 1; mask_ifen = 1;
      m_fl--;
    end else if (m_run) begin
      e_st = 3'd1; e_pc = 1; e_ifen = 1;
      if (br) begin
        {e_pc, e_sel, e_ifen, e_iff, e_idf} = 5'b11111;
        m_fl = FC - 1; m_flush++;
      end else if (ld) begin
        e_pc = 0; e_ifen = 0; e_idf = 1; m_stall++;
      end else if (hop) begin
        e_pc = 0; e_iff = 1; m_dr = DC;
      end
      if (e_pc && !e_sel) m_instr++;
    end else begin
      e_st = 3'd0;
      if (s) m_run = 1;
    end
    o = outs();
    e = {23'd0, e_pc, e_sel, e_ifen, e_iff, e_idf, e_h, e_st};
    if (mask_ifen) begin
      o[6] = 1'b0;
      e[6] = 1'b0;
    end
    chk(tag, o, e);
  endtask

  initial begin
    m_clear();
    // Boot: idle with start low, then start.
    do_reset("boot");
    for (int i = 0; i < 5; i++) cyc("idle", 0, 32'h0, i[0], i[1]);
    cyc("start", 1, 32'h0, 0, 0);
    cyc("run1", 0, 32'h0, 0, 0);
    // Taken branch: redirect, two flush cycles, back to run.
    cyc("br", 0, 32'h0, 0, 1);
    cyc("fl1", 0, 32'h0, 1, 1);
    cyc("fl2", 0, HALT_IR, 0, 0);
    cyc("run2", 0, 32'h0, 0, 0);
    // Load-use beats HALT decode; HALT then drains and halts for good.
    cyc("ld_halt", 0, HALT_IR, 1, 0);
    cyc("halt", 0, HALT_IR, 0, 0);
    for (int i = 0; i < DC; i++) cyc("drain", 0, 32'h0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("halted", i[0], 32'h0, i[1], i[0]);
    // Wrong-path HALT: branch on the 2nd drain cycle.
    do_reset("wp");
    cyc("wp_start", 1, 32'h0, 0, 0);
    cyc("wp_halt", 0, HALT_IR, 0, 0);
    cyc("wp_dr1", 0, 32'h0, 0, 0);
    cyc("wp_dr2br", 0, 32'h0, 0, 1);
    cyc("wp_fl1", 0, 32'h0, 0, 0);
    cyc("wp_fl2", 0, 32'h0, 0, 0);
    cyc("wp_run", 0, 32'h0, 0, 0);
    // Reset in the middle of a flush.
    cyc("mf_br", 0, 32'h0, 0, 1);
    cyc("mf_fl1", 0, 32'h0, 0, 0);
    do_reset("midflush");
    cyc("mf_idle", 0, 32'h0, 0, 1);
    // Random traffic with occasional resets.
    for (int ep = 0; ep < 30; ep++) begin
      do_reset("rnd");
      for (int c = 0; c < 60; c++) begin
        logic [31:0] ir;
        ir = $urandom;
        if ($urandom_range(0, 15) == 0) ir[31:26] = 6'h3F;
        else if (ir[31:26] == 6'h3F) ir[31:26] = 6'h00;
        if ($urandom_range(0, 49) == 0) do_reset("rnd_mid");
        cyc("rnd", ($urandom_range(0, 2) == 0), ir,
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
